dmem_controller: RTL and testbench
==================================

# dmem_controller

Sequencing controller and two-port arbiter in front of the word-only data memory of the RV32IM pipeline. Shares the memory between the MEM-stage load/store unit (CPU port) and a word-wide program/debug loader port. Implements RV32 byte/halfword loads and stores on a word-addressed array with synchronous write, combinational read and 1024 words, using read-modify-write sequencing. Stalls the pipeline while an access is in flight.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held high until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_funct3  in  3  RV32 funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data (low bits used for SB/SH).
- cpu_rdata  out  32  load result, extended per funct3.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done: misaligned or illegal funct3.
- cpu_stall  out  1  cpu_req & ~cpu_done, combinational.
- ld_req, ld_we  in  1  loader request and store flag; word accesses only.
- ld_addr  in  ADDR_W; ld_wdata  in  32.
- ld_rdata  out  32; ld_done  out  1.
- mem_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32; mem_read  out  1; mem_write  out  1.
- mem_rdata  in  32  sampled only while mem_read=1; may be Z otherwise.

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- Requests are sampled only in IDLE. The winner's addr, wdata, funct3, we and port ID are latched.
- Transitions out of IDLE:
  - load → READ
  - SW / loader store → WRITE
  - SB/SH → RMW_READ
  - error → RESP directly, with no memory access.
- READ: mem_read=1. The extracted result is registered into the port's rdata. Next state RESP.
- WRITE: mem_write=1, mem_wdata=latched wdata. Next state RESP.
- RMW_READ: mem_read=1. The word is captured into the merge register. Next state RMW_WRITE.
- RMW_WRITE: mem_write=1, mem_wdata = merged word.
  - SB replaces lane addr[1:0].
  - SH replaces the half selected by addr[1].
  - Next state RESP.
- RESP: the granted port's done=1 for exactly one cycle; err valid. Next state IDLE.
- Load extraction:
  - LB: sign-extended byte at addr[1:0]; LBU: zero-extended.
  - LH: sign-extended half at addr[1]; LHU: zero-extended.
  - LW: full word.
- Errors (CPU only):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - funct3 ∈ {011,110,111}.
  - On error, rdata is forced to 0 and memory is untouched.
- Loader: addr[1:0] ignored, never errors.
- Arbitration (default): fixed CPU priority when both request in IDLE.
- Deasserting req mid-access does not abort the access; done still pulses.
- mem_read and mem_write are decoded from the state register; they are never both high.

## Timing
- Reset values: state IDLE; cpu_rdata, ld_rdata, mem_addr, mem_wdata = 0; cpu_done, cpu_err, ld_done, mem_read, mem_write = 0.
- Accept at cycle 0 (IDLE). Done pulse timing:
  - load/word store: cycle 2 (3 cycles total).
  - SB/SH: cycle 3.
  - error: cycle 1.
- The next request can be accepted on the cycle after RESP.
- rdata holds its value until the next load completion on that port.
- rst_n asserted mid-access: immediate return to IDLE with all outputs zero.
  - If reset hits in RMW_READ, the word is not written.
  - A write in progress on the reset edge is not guaranteed.
- The controller never clears memory contents.

## Configuration
- DMEM_CTRL_RR_EN defined: round-robin arbitration. When both ports request in IDLE, the port not granted last wins. The last-grant flop resets to loader, so the CPU wins the first tie.
- Undefined: fixed CPU priority. The loader is served only when cpu_req=0 in IDLE.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → cpu_rdata=0xDEADBEEF, cpu_done at cycle 2 after accept, cpu_stall high cycles 0–1.
- SB 0x80 @0x13 over 0xDEADBEEF → memory word 0x80ADBEEF, done at cycle 3. Then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080.
- SH 0x1234 @0x12 → word 0x1234BEEF. LHU @0x12 → 0x00001234. LH @0x11 → cpu_err=1, rdata 0, no mem_read, done at cycle 1.
- cpu_req and ld_req in the same cycle:
  - Default: CPU done first, then loader.
  - With DMEM_CTRL_RR_EN, after the first CPU grant the next tie goes to the loader.
- Assert rst_n=0 during RMW_READ of SB @0x10 → mem_write never pulses, word unchanged, all outputs 0, state IDLE.
- Loader SW 0xCAFEF00D @0x7 → written at 0x4, ld_done, no error. CPU LW @0x4 → 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_controller_if.sv
// Bundle of CPU load/store port, loader port and data-memory port for dmem_controller.
interface dmem_controller_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_funct3;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;
  logic [31:0]       ld_rdata;
  logic              ld_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_done,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_done,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_controller.sv
// Data-memory sequencer/arbiter: byte/half/word loads and stores via read-modify-write.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; default is fixed CPU priority.
module dmem_controller #(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  dmem_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ld_rdata_q, ld_rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              port_q, port_d;  // 1 = loader owns the access
  logic              err_q, err_d;
  logic              grant_ld;

  function automatic logic cpu_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return |a;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    if (f3[0]) begin
      if (a[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

`ifdef DMEM_CTRL_RR_EN
  logic last_q;  // 1 = loader was granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            last_q <= 1'b1;
    else if (state_q == IDLE && (bus.cpu_req || bus.ld_req)) last_q <= grant_ld;
  end

  always_comb grant_ld = bus.ld_req & (~bus.cpu_req | ~last_q);
`else
  always_comb grant_ld = bus.ld_req & ~bus.cpu_req;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    f3_d        = f3_q;
    port_d      = port_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ld_req) begin
          port_d = grant_ld;
          if (grant_ld) begin
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
            f3_d    = 3'b010;
            err_d   = 1'b0;
            state_d = bus.ld_we ? WRITE : READ;
          end else begin
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            f3_d    = bus.cpu_funct3;
            err_d   = cpu_bad(bus.cpu_funct3, bus.cpu_addr[1:0]);
            if (err_d) begin
              cpu_rdata_d = '0;
              state_d     = RESP;
            end else if (!bus.cpu_we)                  state_d = READ;
            else if (bus.cpu_funct3[1:0] == 2'b10)     state_d = WRITE;
            else                                       state_d = RMW_READ;
          end
        end
      end
      READ: begin
        if (port_q) ld_rdata_d  = bus.mem_rdata;
        else        cpu_rdata_d = load_ext(bus.mem_rdata, f3_q, addr_q[1:0]);
        state_d = RESP;
      end
      WRITE:     state_d = RESP;
      RMW_READ: begin
        merge_d = bus.mem_rdata;
        state_d = RMW_WRITE;
      end
      RMW_WRITE: state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
      f3_q        <= '0;
      port_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
      f3_q        <= f3_d;
      port_q      <= port_d;
      err_q       <= err_d;
    end
  end

  // Memory strobes and completion flags decode straight from state so reset clears them at once.
  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_read  = (state_q == READ)  || (state_q == RMW_READ);
  assign bus.mem_write = (state_q == WRITE) || (state_q == RMW_WRITE);
  assign bus.mem_wdata = (state_q == WRITE)     ? wdata_q :
                         (state_q == RMW_WRITE) ? merge(merge_q, wdata_q, f3_q, addr_q[1:0]) :
                                                  '0;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.cpu_done  = (state_q == RESP) && !port_q;
  assign bus.ld_done   = (state_q == RESP) && port_q;
  assign bus.cpu_err   = (state_q == RESP) && !port_q && err_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller: directed plan cases plus randomized traffic vs a word-array model.
`timescale 1ns/1ps
module tb_dmem_controller;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dmem_controller_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_controller #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[11:2]] : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;   // 1 = loader
    logic [31:0] rdata;  // expected port rdata after done
    bit          err;
    int          lat;
    int          issue;
    bit          acc;    // expect any memory strobe
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] refmem [1024];
  logic [31:0] last_cpu = '0, last_ld = '0;
  bit          last_grant = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the ISA rules: a plain word array with byte/half lanes.
  task automatic model(input bit port, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int idx, sh, hs;
    logic [31:0] w, b, h, r;
    idx = int'(a[11:2]);
    sh  = 8 * int'(a[1:0]);
    hs  = a[1] ? 16 : 0;
    w   = refmem[idx];
    b   = (w >> sh) & 32'hFF;
    h   = (w >> hs) & 32'hFFFF;
    last_grant = port;
    e.port = port; e.err = 1'b0; e.acc = 1'b1; e.lat = 2; e.issue = 0;
    if (port) begin
      if (we) refmem[idx] = d;
      else    last_ld = w;
      e.rdata = last_ld;
      return;
    end
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 ||
        ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00)) begin
      e.err = 1'b1; e.acc = 1'b0; e.lat = 1; last_cpu = '0; e.rdata = '0;
      return;
    end
    if (!we) begin
      case (f3)
        3'b000:  r = b[7]  ? (b | 32'hFFFF_FF00) : b;
        3'b100:  r = b;
        3'b001:  r = h[15] ? (h | 32'hFFFF_0000) : h;
        3'b101:  r = h;
        default: r = w;
      endcase
      last_cpu = r;
    end else if (f3 == 3'b010) begin
      refmem[idx] = d;
    end else if (f3 == 3'b000) begin
      refmem[idx] = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      e.lat = 3;
    end else begin
      refmem[idx] = (w & ~(32'hFFFF << hs)) | ((d & 32'hFFFF) << hs);
      e.lat = 3;
    end
    e.rdata = last_cpu;
  endtask

  task automatic drive(input bit port, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_funct3 = f3; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  task automatic wait_done(input bit port);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = port ? bus.ld_done : bus.cpu_done;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout: port %0d got no done in 40 cycles, expected done", port);
    end
    #1;
    if (port) bus.ld_req = 1'b0;
    else      bus.cpu_req = 1'b0;
  endtask

  task automatic do_op(input bit port, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    model(port, we, f3, a, d, e);
    e.issue = cyc;
    sbq.push_back(e);
    #1 drive(port, we, f3, a, d);
    wait_done(port);
  endtask

  task automatic do_tie(input bit cwe, input logic [2:0] cf3, input logic [31:0] ca,
                        input logic [31:0] cd, input bit lwe, input logic [31:0] la,
                        input logic [31:0] ld);
    exp_t e1, e2;
    bit first;
`ifdef DMEM_CTRL_RR_EN
    first = ~last_grant;
`else
    first = 1'b0;
`endif
    @(negedge clk);
    if (first) begin
      model(1'b1, lwe, 3'b010, la, ld, e1);
      model(1'b0, cwe, cf3, ca, cd, e2);
    end else begin
      model(1'b0, cwe, cf3, ca, cd, e1);
      model(1'b1, lwe, 3'b010, la, ld, e2);
    end
    e1.issue = cyc;
    e2.issue = cyc;
    e2.lat   = e1.lat + 1 + e2.lat;
    sbq.push_back(e1);
    sbq.push_back(e2);
    #1;
    drive(1'b0, cwe, cf3, ca, cd);
    drive(1'b1, lwe, 3'b010, la, ld);
    wait_done(first);
    wait_done(~first);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, '0);
    chk({tag, "_ld_rdata"},  bus.ld_rdata,  '0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_strobes"},
        {26'b0, bus.cpu_done, bus.cpu_err, bus.ld_done, bus.mem_read, bus.mem_write, bus.cpu_stall},
        '0);
  endtask

  function automatic logic [2:0] pick_f3(input bit we);
    int k;
    logic [2:0] f;
    if (we) begin
      k = $urandom_range(0, 7);
      case (k)
        0, 1:    f = 3'b000;
        2, 3:    f = 3'b001;
        4, 5, 6: f = 3'b010;
        default: f = 3'b111;
      endcase
    end else begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    f = 3'b000;
        2, 3:    f = 3'b001;
        4, 5:    f = 3'b010;
        6:       f = 3'b100;
        7:       f = 3'b101;
        8:       f = 3'b011;
        default: f = 3'b110;
      endcase
    end
    return f;
  endfunction

  // Monitor: pops an expectation whenever either port signals completion.
  bit   acc_seen = 1'b0;
  exp_t me;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      acc_seen = 1'b0;
    end else begin
      if (bus.mem_read && bus.mem_write) begin
        total++; bad++;
        $display("FAIL rw_overlap: got read=1 write=1 expected exclusive");
      end
      if (bus.cpu_stall !== (bus.cpu_req && !bus.cpu_done)) begin
        total++; bad++;
        $display("FAIL stall: got %b expected %b", bus.cpu_stall, bus.cpu_req && !bus.cpu_done);
      end
      if (bus.mem_read || bus.mem_write) acc_seen = 1'b1;
      if (bus.cpu_done || bus.ld_done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard expected none");
        end else begin
          me = sbq.pop_front();
          chk("done_port", {30'b0, bus.cpu_done, bus.ld_done}, {30'b0, ~me.port, me.port});
          chk("rdata", me.port ? bus.ld_rdata : bus.cpu_rdata, me.rdata);
          chk("err", {31'b0, bus.cpu_err}, {31'b0, me.err});
          chk("latency", 32'(cyc - me.issue), 32'(me.lat));
          chk("mem_access", {31'b0, acc_seen}, {31'b0, me.acc});
        end
        acc_seen = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          port, we;
    logic [2:0]  f3;
    logic [31:0] a, d;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_funct3 = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 0;  bus.ld_we = 0;  bus.ld_addr = '0;    bus.ld_wdata = '0;
    for (int i = 0; i < 1024; i++) refmem[i] = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    chk_all_zero("reset");
    #1 rst_n = 1'b1;

    do_op(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    do_op(0, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_deadbeef", bus.cpu_rdata, 32'hDEAD_BEEF);
    do_op(0, 1, 3'b000, 32'h13, 32'h0000_0080);
    chk("sb_word", mem[4], 32'h80AD_BEEF);
    do_op(0, 0, 3'b000, 32'h13, 32'h0);
    chk("lb_sext", bus.cpu_rdata, 32'hFFFF_FF80);
    do_op(0, 0, 3'b100, 32'h13, 32'h0);
    chk("lbu_zext", bus.cpu_rdata, 32'h0000_0080);
    do_op(0, 1, 3'b001, 32'h12, 32'h0000_1234);
    chk("sh_word", mem[4], 32'h1234_BEEF);
    do_op(0, 0, 3'b101, 32'h12, 32'h0);
    chk("lhu", bus.cpu_rdata, 32'h0000_1234);
    do_op(0, 0, 3'b001, 32'h11, 32'h0);
    chk("lh_mis_rdata", bus.cpu_rdata, 32'h0);

    do_op(1, 1, 3'b010, 32'h7, 32'hCAFE_F00D);
    chk("ld_sw_word", mem[1], 32'hCAFE_F00D);
    do_op(0, 0, 3'b010, 32'h4, 32'h0);
    chk("lw_cafef00d", bus.cpu_rdata, 32'hCAFE_F00D);
    do_op(1, 0, 3'b010, 32'h12, 32'h0);
    chk("ld_lw", bus.ld_rdata, 32'h1234_BEEF);

    // Reset while the SB is in its read phase: nothing may be written.
    @(negedge clk);
    #1 drive(0, 1, 3'b000, 32'h10, 32'h0000_0055);
    @(posedge clk);
    #1 chk("rmw_read_phase", {31'b0, bus.mem_read}, 32'h1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1 chk_all_zero("midreset");
    last_cpu = '0; last_ld = '0; last_grant = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_word_kept", mem[4], 32'h1234_BEEF);

    do_tie(0, 3'b010, 32'h10, 32'h0, 0, 32'h4, 32'h0);
    do_tie(1, 3'b000, 32'h10, 32'h0000_00A5, 0, 32'h10, 32'h0);

    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = pick_f3(we);
      a  = 32'($urandom_range(0, 63));
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (f3 == 3'b010) a[1:0] = 2'b00;
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) begin
        do_tie(we, f3, a, d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
      end else begin
        port = ($urandom_range(0, 3) == 0);
        do_op(port, we, f3, a, d);
      end
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], refmem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
